// File: rtl/fwd_hazard_tracker_if.sv
// Decode-side bundle for the forwarding/hazard tracker.
// Master is the decode stage, slave is the tracker.
interface fwd_hazard_tracker_if #(
  parameter int NSRC = 2,
  parameter int REGW = 5,
  parameter int SELW = 2,
  parameter int CNTW = 16
);
  logic                   id_valid;
  logic [REGW-1:0]        id_rd;
  logic                   id_wb;
  logic                   id_is_load;
  logic [NSRC*REGW-1:0]   id_rs;
  logic [NSRC-1:0]        id_rs_used;
  logic                   flush;
  logic [NSRC*SELW-1:0]   fwd_sel;
  logic                   stall;
  logic [CNTW-1:0]        stall_cnt;

  modport master (
    output id_valid,
    output id_rd,
    output id_wb,
    output id_is_load,
    output id_rs,
    output id_rs_used,
    output flush,
    input  fwd_sel,
    input  stall,
    input  stall_cnt
  );

  modport slave (
    input  id_valid,
    input  id_rd,
    input  id_wb,
    input  id_is_load,
    input  id_rs,
    input  id_rs_used,
    input  flush,
    output fwd_sel,
    output stall,
    output stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_tracker.sv
// Tracks in-flight destinations, drives operand forwarding
// selects and the load-use stall with a saturating counter.
module fwd_hazard_tracker #(
  parameter int NSRC       = 2,
  parameter int NSTAGES    = 3,
  parameter int REGW       = 5,
  parameter int LOAD_READY = 1,
  parameter int SELW       = $clog2(NSTAGES+1),
  parameter int CNTW       = 16
) (
  input logic clk,
  input logic rst_n,
  fwd_hazard_tracker_if.slave bus
);

  typedef struct packed {
    logic            v;
    logic [REGW-1:0] rd;
    logic            wb;
    logic            ld;
  } ent_t;

  ent_t               ent_q [NSTAGES];
  logic [NSTAGES-1:0] hit [NSRC];
  logic [SELW-1:0]    sel [NSRC];
  logic [NSRC-1:0]    haz;
  logic               stall;
  logic [CNTW-1:0]    cnt_q;

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      for (int k = 0; k < NSTAGES; k++) begin
        hit[i][k] = ent_q[k].v
                  & ent_q[k].wb
                  & (ent_q[k].rd != '0)
                  & (ent_q[k].rd == bus.id_rs[i*REGW +: REGW])
                  & bus.id_rs_used[i];
      end
    end
  end

  // Scan oldest to youngest so the youngest producer wins.
  always_comb begin
    haz = '0;
    for (int i = 0; i < NSRC; i++) begin
      sel[i] = '0;
      for (int k = NSTAGES-1; k >= 0; k--) begin
        if (hit[i][k]) begin
          sel[i] = SELW'(k+1);
          haz[i] = ent_q[k].ld & (k < LOAD_READY);
        end
      end
    end
  end

  always_comb begin
    bus.fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      bus.fwd_sel[i*SELW +: SELW] = sel[i];
    end
  end

  assign stall         = bus.id_valid & ~bus.flush & (|haz);
  assign bus.stall     = stall;
  assign bus.stall_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGES; k++) begin
        ent_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      ent_q[0] <= '{
        v:  bus.id_valid & ~stall & ~bus.flush,
        rd: bus.id_rd,
        wb: bus.id_wb,
        ld: bus.id_is_load
      };
      for (int k = 1; k < NSTAGES; k++) begin
        ent_q[k] <= ent_q[k-1];
      end
      if (stall && cnt_q != '1) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Directed bench for fwd_hazard_tracker: driver queues expected
// results, a negedge monitor pops and compares them.
module tb_fwd_hazard_tracker;

  logic clk;
  logic rst_n;

  fwd_hazard_tracker_if #(
    .NSRC(2), .REGW(5), .SELW(2), .CNTW(16)
  ) bus ();
  fwd_hazard_tracker_if #(
    .NSRC(2), .REGW(5), .SELW(2), .CNTW(4)
  ) bus4 ();

  assign bus4.id_valid   = bus.id_valid;
  assign bus4.id_rd      = bus.id_rd;
  assign bus4.id_wb      = bus.id_wb;
  assign bus4.id_is_load = bus.id_is_load;
  assign bus4.id_rs      = bus.id_rs;
  assign bus4.id_rs_used = bus.id_rs_used;
  assign bus4.flush      = bus.flush;

  fwd_hazard_tracker #(
    .NSRC(2), .NSTAGES(3), .REGW(5),
    .LOAD_READY(1), .SELW(2), .CNTW(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  fwd_hazard_tracker #(
    .NSRC(2), .NSTAGES(3), .REGW(5),
    .LOAD_READY(1), .SELW(2), .CNTW(4)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  typedef struct packed {
    logic [7:0]  id;
    logic [1:0]  s0;
    logic [1:0]  s1;
    logic        st;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vid    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int id,
                     input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL v%0d %s got %0d want %0d", id, nm, got, want);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    int   c4;
    if (q.size() != 0) begin
      e  = q.pop_front();
      c4 = (int'(e.cnt) > 15) ? 15 : int'(e.cnt);
      chk("sel0", e.id, bus.fwd_sel[1:0], e.s0);
      chk("sel1", e.id, bus.fwd_sel[3:2], e.s1);
      chk("stall", e.id, bus.stall, e.st);
      chk("cnt", e.id, bus.stall_cnt, e.cnt);
      chk("cnt4", e.id, bus4.stall_cnt, c4);
    end
  end

  task automatic step(
    input bit vl, input int rd, input bit wb, input bit ld,
    input int r0, input int r1, input bit [1:0] used,
    input bit fl, input int e0, input int e1,
    input bit est, input int ecnt
  );
    exp_t e;
    @(posedge clk);
    #1;
    bus.id_valid   = vl;
    bus.id_rd      = rd[4:0];
    bus.id_wb      = wb;
    bus.id_is_load = ld;
    bus.id_rs      = {r1[4:0], r0[4:0]};
    bus.id_rs_used = used;
    bus.flush      = fl;
    vid++;
    e.id  = vid[7:0];
    e.s0  = e0[1:0];
    e.s1  = e1[1:0];
    e.st  = est;
    e.cnt = ecnt[15:0];
    q.push_back(e);
  endtask

  task automatic idle_in();
    bus.id_valid   = 1'b0;
    bus.id_rd      = '0;
    bus.id_wb      = 1'b0;
    bus.id_is_load = 1'b0;
    bus.id_rs      = '0;
    bus.id_rs_used = '0;
    bus.flush      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    // reset state
    step(1, 5, 1, 0, 1, 2, 2'b11, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_in();
    // forwarding distance
    step(1, 5, 1, 0, 1, 2, 2'b11, 0, 0, 0, 0, 0);
    step(1, 6, 1, 0, 5, 5, 2'b11, 0, 1, 1, 0, 0);
    step(1, 10, 1, 0, 6, 5, 2'b11, 0, 1, 2, 0, 0);
    step(0, 0, 0, 0, 5, 6, 2'b11, 0, 3, 2, 0, 0);
    step(1, 11, 1, 0, 6, 5, 2'b11, 0, 3, 0, 0, 0);
    step(1, 12, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(1, 13, 1, 0, 12, 12, 2'b11, 0, 2, 2, 0, 0);
    step(0, 0, 0, 0, 12, 12, 2'b11, 0, 3, 3, 0, 0);
    step(0, 0, 0, 0, 12, 12, 2'b11, 0, 0, 0, 0, 0);
    step(1, 14, 1, 0, 13, 13, 2'b01, 0, 3, 0, 0, 0);
    // youngest wins, wb=0 and x0 never match
    step(1, 7, 1, 0, 1, 2, 2'b00, 0, 0, 0, 0, 0);
    step(1, 15, 1, 0, 14, 7, 2'b11, 0, 2, 1, 0, 0);
    step(1, 7, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0);
    step(1, 16, 1, 0, 7, 15, 2'b11, 0, 1, 2, 0, 0);
    step(1, 17, 0, 0, 16, 7, 2'b11, 0, 1, 2, 0, 0);
    step(1, 0, 1, 0, 17, 7, 2'b11, 0, 0, 3, 0, 0);
    step(1, 18, 1, 0, 0, 16, 2'b11, 0, 0, 3, 0, 0);
    // load-use
    step(1, 8, 1, 1, 1, 0, 2'b01, 0, 0, 0, 0, 0);
    step(1, 9, 1, 0, 8, 0, 2'b11, 0, 1, 0, 1, 0);
    step(1, 9, 1, 0, 8, 0, 2'b11, 0, 2, 0, 0, 1);
    step(1, 20, 1, 1, 9, 0, 2'b00, 0, 0, 0, 0, 1);
    step(1, 20, 1, 0, 20, 9, 2'b11, 0, 1, 2, 1, 1);
    step(1, 20, 1, 0, 20, 9, 2'b11, 0, 2, 3, 0, 2);
    // younger load behind an older non-load producer
    step(1, 20, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2);
    step(1, 21, 1, 0, 20, 0, 2'b11, 0, 1, 0, 1, 2);
    step(1, 21, 1, 0, 20, 0, 2'b11, 0, 2, 0, 0, 3);
    // flush during hazard
    step(1, 8, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 3);
    step(1, 9, 1, 0, 8, 0, 2'b11, 1, 1, 0, 0, 3);
    step(0, 0, 0, 0, 9, 21, 2'b11, 0, 0, 3, 0, 3);
    // async reset in the middle of a stall cycle
    step(1, 8, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 3);
    step(1, 9, 1, 0, 8, 8, 2'b11, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_in();
    step(1, 9, 1, 0, 8, 8, 2'b11, 0, 0, 0, 0, 0);
    // counter saturation on the 4-bit instance
    for (int j = 0; j < 20; j++) begin
      step(1, 8, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, j);
      step(1, 9, 1, 0, 8, 8, 2'b11, 0, 1, 1, 1, j);
      step(1, 9, 1, 0, 8, 8, 2'b11, 0, 2, 2, 0, j+1);
    end
    step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 20);
    @(negedge clk);
    #1;
    chk("drain", 0, q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
